// File: rtl/nn_mem_pkg.sv
// ============================================================================
// Module : nn_mem_pkg
// Brief  : Shared constants, requester ids and arbiter state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_mem_pkg;

    localparam int REQ_WGT = 0;
    localparam int REQ_INP = 1;
    localparam int REQ_OUT = 2;
    localparam int NREQ    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot3(input logic [1:0] idx);
        onehot3 = 3'b001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_sram_arbiter_rr_pick3.sv
// ============================================================================
// Module : rr_pick3
// Brief  : Combinational 3-way round-robin picker; first set req from ptr up.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick3
    import nn_mem_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            valid,
    output logic [1:0]      idx
);

    localparam logic [1:0] c_wgt = 2'(REQ_WGT);
    localparam logic [1:0] c_inp = 2'(REQ_INP);
    localparam logic [1:0] c_out = 2'(REQ_OUT);

    assign valid = |req;

    // idx is don't-care when valid is low; ptr never reaches 3
    always_comb begin
        idx = c_wgt;
        case (ptr)
            2'd1:    idx = req[REQ_INP] ? c_inp : (req[REQ_OUT] ? c_out : c_wgt);
            2'd2:    idx = req[REQ_OUT] ? c_out : (req[REQ_WGT] ? c_wgt : c_inp);
            default: idx = req[REQ_WGT] ? c_wgt : (req[REQ_INP] ? c_inp : c_out);
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/nn_sram_arbiter.sv
// ============================================================================
// Module : nn_sram_arbiter
// Brief  : Round-robin burst arbiter sharing one single-port SRAM among the
//          weight loader, input loader and output writer.
//          Optional per-requester beat counters: define NN_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_sram_arbiter
    import nn_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 16,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        wr_pop,
    output logic [NREQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [NREQ-1:0]        done,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [NREQ*16-1:0]     stat_beats
);

    arb_state_t          r_state;
    logic [1:0]          r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [NREQ-1:0]     r_done;
    logic [NREQ-1:0]     r_rd_valid;

    logic                w_valid;
    logic [1:0]          w_idx;
    logic [LEN_W-1:0]    w_len_raw;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W-1:0]   w_base;
    logic [DATA_W-1:0]   w_wdata;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_len_raw = req_len[w_idx*LEN_W +: LEN_W];
    assign w_len     = (w_len_raw > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : w_len_raw;
    assign w_base    = req_addr[w_idx*ADDR_W +: ADDR_W];

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_wdata = w_wdata | req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // r_rem holds the beats still to issue after the one currently on the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd0;
            r_gnt      <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_rem      <= '0;
            r_done     <= '0;
            r_rd_valid <= '0;
        end else begin
            r_done     <= '0;
            r_rd_valid <= r_gnt & {NREQ{r_mem_en & ~r_mem_we}};
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_ptr <= (w_idx == 2'(REQ_OUT)) ? 2'd0 : w_idx + 2'd1;
                        if (w_len == '0) begin
                            r_done  <= onehot3(w_idx);
                            r_state <= ST_DONE;
                        end else begin
                            r_gnt      <= onehot3(w_idx);
                            r_mem_en   <= 1'b1;
                            r_mem_we   <= req_we[w_idx];
                            r_mem_addr <= w_base;
                            r_rem      <= w_len - LEN_W'(1);
                            r_state    <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (r_rem == '0) begin
                        r_gnt    <= '0;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_done   <= r_gnt;
                        r_state  <= ST_DONE;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_rem      <= r_rem - LEN_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_wdata;
    assign wr_pop    = r_gnt & {NREQ{r_mem_en & r_mem_we}};
    assign rd_valid  = r_rd_valid;
    assign rd_data   = mem_rdata;
    assign done      = r_done;

`ifdef NN_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [15:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (r_mem_en && r_gnt[i] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign stat_beats[i*16 +: 16] = r_cnt;
    end
`else
    assign stat_beats = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nn_sram_arbiter.sv
// ============================================================================
// Module : tb_nn_sram_arbiter
// Brief  : Directed self-checking bench for nn_sram_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_sram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;

    logic                clk;
    logic                rst;
    logic [2:0]          req;
    logic [2:0]          req_we;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*LEN_W-1:0]  req_len;
    logic [3*DATA_W-1:0] req_wdata;
    logic [2:0]          gnt;
    logic [2:0]          wr_pop;
    logic [2:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic [2:0]          done;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [47:0]         stat_beats;

    int n_chk = 0;
    int n_err = 0;
    int exp_beats [3] = '{0, 0, 0};

    nn_sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .wr_pop     (wr_pop),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .done       (done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stat_beats (stat_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd_pattern(input logic [9:0] a);
        return 16'hA5A5 ^ {6'd0, a};
    endfunction

    // SRAM model: read data appears one cycle after a read beat
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rd_pattern(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] exp_stats();
`ifdef NN_ARB_STATS_EN
        return {16'(exp_beats[2]), 16'(exp_beats[1]), 16'(exp_beats[0])};
`else
        return 48'd0;
`endif
    endfunction

    // Called during an IDLE cycle; returns during the following IDLE cycle.
    task automatic burst(input int who, input bit we, input logic [9:0] addr, input int len_in);
        int          n;
        logic [2:0]  oh;
        logic [9:0]  a;
        oh = 3'b001 << who;
        n  = (len_in > 16) ? 16 : len_in;
        req_we[who]                  = we;
        req_addr[who*ADDR_W +: ADDR_W] = addr;
        req_len[who*LEN_W +: LEN_W]  = 5'(len_in);
        req_wdata[who*DATA_W +: DATA_W] = 16'hC000;
        req[who]                     = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (we && k > 0) req_wdata[who*DATA_W +: DATA_W] = 16'hC000 + 16'(k);
            #1;
            a = addr + 10'(k);
            chk("beat_gnt", gnt, oh);
            chk("beat_en", mem_en, 1'b1);
            chk("beat_we", mem_we, we);
            chk("beat_addr", mem_addr, a);
            chk("beat_pop", wr_pop, we ? oh : 3'b000);
            chk("beat_rdv", rd_valid, (we || k == 0) ? 3'b000 : oh);
            chk("beat_done", done, 3'b000);
            if (we) chk("beat_wdata", mem_wdata, 16'hC000 + 16'(k));
            else if (k > 0) chk("beat_rdata", rd_data, rd_pattern(a - 10'd1));
        end
        @(posedge clk); #1;
        chk("done_gnt", gnt, 3'b000);
        chk("done_en", mem_en, 1'b0);
        chk("done_pulse", done, oh);
        chk("done_rdv", rd_valid, (we || n == 0) ? 3'b000 : oh);
        if (!we && n > 0) chk("done_rdata", rd_data, rd_pattern(addr + 10'(n - 1)));
        exp_beats[who] += n;
        req = 3'b000;
        @(posedge clk); #1;
        chk("idle_done", done, 3'b000);
        chk("idle_rdv", rd_valid, 3'b000);
    endtask

    initial begin
        int          seq [4] = '{0, 1, 2, 0};
        int          own;
        int          ph;
        logic [2:0]  done_seen;

        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 10'd0);
        chk("rst_pop", wr_pop, 3'b000);
        chk("rst_rdv", rd_valid, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_stat", stat_beats, 48'd0);
        rst = 1'b0;

        // contention: all three request two-beat reads from rr_ptr=0
        req_addr = {10'h300, 10'h200, 10'h100};
        req_len  = {5'd2, 5'd2, 5'd2};
        req      = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            own = seq[(c - 1) / 4];
            ph  = (c - 1) % 4;
            chk("cont_gnt", gnt, (ph < 2) ? (3'b001 << own) : 3'b000);
            chk("cont_done", done, (ph == 2) ? (3'b001 << own) : 3'b000);
        end
        req = 3'b000;
        exp_beats[0] += 4;
        exp_beats[1] += 2;
        exp_beats[2] += 2;

        burst(0, 1'b0, 10'h010, 4);
        burst(2, 1'b1, 10'h040, 3);
        burst(0, 1'b0, 10'h3FE, 4);
        burst(1, 1'b0, 10'h000, 0);

        // after the zero-length grant to requester 1, requester 2 wins next
        req_len = {5'd1, 5'd1, 5'd1};
        req     = 3'b111;
        @(posedge clk); #1;
        chk("next_gnt", gnt, 3'b100);
        chk("next_en", mem_en, 1'b1);
        @(posedge clk); #1;
        chk("next_done", done, 3'b100);
        req = 3'b000;
        exp_beats[2] += 1;
        @(posedge clk); #1;

        burst(1, 1'b0, 10'h080, 20);
        chk("stat_before_rst", stat_beats, exp_stats());

        // reset during the third beat of an eight-beat read
        req_we   = '0;
        req_addr = {10'h0, 10'h0, 10'h020};
        req_len  = {5'd0, 5'd0, 5'd8};
        req      = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_addr", mem_addr, 10'h022);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 3'b000;
        chk("abort_gnt", gnt, 3'b000);
        chk("abort_en", mem_en, 1'b0);
        chk("abort_addr", mem_addr, 10'd0);
        chk("abort_rdv", rd_valid, 3'b000);
        chk("abort_done", done, 3'b000);
        chk("abort_stat", stat_beats, 48'd0);
        done_seen = '0;
        repeat (4) begin
            @(posedge clk); #1;
            done_seen = done_seen | done | gnt;
        end
        chk("abort_quiet", done_seen, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
